// File: rtl/rc5_serial_host.sv
// Host side of the RC5 serialized wrapper: slot-multiplexes one job onto the
// wrapper's serial bus, waits for done, and de-serializes the four results.
module rc5_serial_host #(
    parameter int W       = 64,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         iValid,
    output logic         oReady,
    input  logic [1:0]   iMode,
    input  logic [W-1:0] iA,
    input  logic [W-1:0] iB,
    input  logic [W-1:0] iA_cipher,
    input  logic [W-1:0] iB_cipher,
    output logic [W-1:0] oSerial,
    input  logic [W-1:0] iSerial,
    output logic         oStartCipher,
    output logic         oStartDecipher,
    input  logic         iDoneCipher,
    input  logic         iDoneDecipher,
    output logic         oResultValid,
    input  logic         iResultReady,
    output logic [W-1:0] oA_cipher,
    output logic [W-1:0] oB_cipher,
    output logic [W-1:0] oA_decipher,
    output logic [W-1:0] oB_decipher,
    output logic         oError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [1:0]      slot;
    logic [2:0]      cnt;
    logic [2:0]      cnt_n;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_n;
    logic [1:0]      mode;
    logic            done_c;
    logic            done_c_n;
    logic            done_d;
    logic            done_d_n;
    logic            err;
    logic            err_n;
    logic            start_c;
    logic            start_c_n;
    logic            start_d;
    logic            start_d_n;
    logic            accept;
    logic            all_done;
    logic [W-1:0]    tx [4];
    logic [W-1:0]    rx [4];

    // Free-running slot counter, in lockstep with the wrapper's mux counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot <= 2'd0;
        end else begin
            slot <= slot + 2'd1;
        end
    end

    // Job words and mode are latched only when a job is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                tx[i] <= '0;
            end
            mode <= 2'b00;
        end else if (accept) begin
            tx[0] <= iA;
            tx[1] <= iB;
            tx[2] <= iA_cipher;
            tx[3] <= iB_cipher;
            mode  <= iMode;
        end
    end

    // Wrapper output is registered, so the word seen now belongs to slot-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                rx[i] <= '0;
            end
        end else if (state == S_CAPTURE) begin
            rx[slot - 2'd1] <= iSerial;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            to_cnt  <= '0;
            done_c  <= 1'b0;
            done_d  <= 1'b0;
            err     <= 1'b0;
            start_c <= 1'b0;
            start_d <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            to_cnt  <= to_n;
            done_c  <= done_c_n;
            done_d  <= done_d_n;
            err     <= err_n;
            start_c <= start_c_n;
            start_d <= start_d_n;
        end
    end

    // Next-state logic; strobes are computed one cycle early so they come
    // out of flops for exactly the START cycle
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        to_n      = to_cnt;
        done_c_n  = done_c;
        done_d_n  = done_d;
        err_n     = err;
        start_c_n = 1'b0;
        start_d_n = 1'b0;
        accept    = 1'b0;
        all_done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (iValid) begin
                    accept  = 1'b1;
                    state_n = S_LOAD;
                    cnt_n   = 3'd0;
                end
            end
            S_LOAD: begin
                if (cnt == 3'd3) begin
                    state_n   = S_START;
                    start_c_n = mode[0];
                    start_d_n = mode[1];
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_START: begin
                // Clear the flags but keep a done arriving on this edge
                done_c_n = iDoneCipher;
                done_d_n = iDoneDecipher;
                to_n     = '0;
                cnt_n    = 3'd0;
                state_n  = (mode == 2'b00) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                done_c_n = done_c | iDoneCipher;
                done_d_n = done_d | iDoneDecipher;
                all_done = (done_c_n | ~mode[0]) & (done_d_n | ~mode[1]);
                if (all_done) begin
                    state_n = S_CAPTURE;
                    cnt_n   = 3'd0;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_RESULT;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (cnt == 3'd4) begin
                    state_n = S_RESULT;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            S_RESULT: begin
                if (iResultReady) begin
                    state_n = S_IDLE;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign oReady         = (state == S_IDLE);
    assign oResultValid   = (state == S_RESULT);
    assign oError         = err;
    assign oStartCipher   = start_c;
    assign oStartDecipher = start_d;
    assign oSerial        = tx[slot];
    assign oA_cipher      = rx[0];
    assign oB_cipher      = rx[1];
    assign oA_decipher    = rx[2];
    assign oB_decipher    = rx[3];

endmodule

// File: tb/tb_rc5_serial_host.sv
// Bench for rc5_serial_host: job table plus random jobs against a latency
// and data model, with a registered 4-slot wrapper model on the serial bus.
module tb_rc5_serial_host;

    localparam int W  = 64;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         iValid = 1'b0;
    logic         oReady;
    logic [1:0]   iMode = 2'b00;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic [W-1:0] iA_cipher = '0;
    logic [W-1:0] iB_cipher = '0;
    logic [W-1:0] oSerial;
    logic [W-1:0] iSerial;
    logic         oStartCipher;
    logic         oStartDecipher;
    logic         iDoneCipher = 1'b0;
    logic         iDoneDecipher = 1'b0;
    logic         oResultValid;
    logic         iResultReady = 1'b0;
    logic [W-1:0] oA_cipher;
    logic [W-1:0] oB_cipher;
    logic [W-1:0] oA_decipher;
    logic [W-1:0] oB_decipher;
    logic         oError;

    always #5 clk = ~clk;

    rc5_serial_host #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .iValid(iValid),
        .oReady(oReady),
        .iMode(iMode),
        .iA(iA),
        .iB(iB),
        .iA_cipher(iA_cipher),
        .iB_cipher(iB_cipher),
        .oSerial(oSerial),
        .iSerial(iSerial),
        .oStartCipher(oStartCipher),
        .oStartDecipher(oStartDecipher),
        .iDoneCipher(iDoneCipher),
        .iDoneDecipher(iDoneDecipher),
        .oResultValid(oResultValid),
        .iResultReady(iResultReady),
        .oA_cipher(oA_cipher),
        .oB_cipher(oB_cipher),
        .oA_decipher(oA_decipher),
        .oB_decipher(oB_decipher),
        .oError(oError)
    );

    typedef struct {
        logic [1:0] mode;
        int         dc;
        int         dd;
        int         hold;
        int         align;
        int         lat;
        bit         err;
    } job_t;

    int errors = 0;
    int checks = 0;
    int tick;

    logic [W-1:0] res [4];
    logic [W-1:0] tx_m [4];
    logic [W-1:0] rx_m [4];
    logic [W-1:0] words [4];
    logic [1:0]   wslot;
    logic [W-1:0] wout;

    // Cycles since reset release; slot is tick mod 4
    always @(posedge clk or negedge rst) begin
        if (!rst) tick <= 0;
        else tick <= tick + 1;
    end

    // Wrapper model: registered 4-slot output mux
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wslot <= 2'd0;
            wout  <= '0;
        end else begin
            wslot <= wslot + 2'd1;
            wout  <= res[wslot];
        end
    end
    assign iSerial = wout;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from accept edge to result: 4 load + 1 start, then wait for
    // the last enabled done (earliest exit one cycle after START), then 5
    // capture cycles; timeout fires after TO wait cycles.
    function automatic int model_lat(input logic [1:0] m, input int dc,
                                     input int dd, output bit err);
        int d;
        err = 1'b0;
        if (m == 2'b00) return 10;
        d = 6;
        if (m[0]) begin
            if (dc < 0) err = 1'b1;
            else if (5 + dc > d) d = 5 + dc;
        end
        if (m[1]) begin
            if (dd < 0) err = 1'b1;
            else if (5 + dd > d) d = 5 + dd;
        end
        if (err || d > 5 + TO) begin
            err = 1'b1;
            return 5 + TO;
        end
        return d + 5;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_outs(input string tag);
        chkw({tag, "_a_c"}, oA_cipher, rx_m[0]);
        chkw({tag, "_b_c"}, oB_cipher, rx_m[1]);
        chkw({tag, "_a_d"}, oA_decipher, rx_m[2]);
        chkw({tag, "_b_d"}, oB_decipher, rx_m[3]);
    endtask

    task automatic wait_align(input int s);
        for (int i = 0; i < 8; i++) begin
            if (tick % 4 == s) break;
            @(negedge clk);
        end
    endtask

    task automatic run_job(input job_t j);
        int lat;
        wait_align(j.align);
        iA = words[0];
        iB = words[1];
        iA_cipher = words[2];
        iB_cipher = words[3];
        iMode = j.mode;
        iValid = 1'b1;
        chk1("ready_idle", oReady, 1'b1);
        for (int i = 0; i < 4; i++) tx_m[i] = words[i];
        lat = -1;
        for (int k = 0; k <= TO + 20; k++) begin
            @(negedge clk);
            // Requests while busy must be ignored
            iValid = 1'($urandom_range(0, 1));
            iA = rnd64();
            iB = rnd64();
            iA_cipher = rnd64();
            iB_cipher = rnd64();
            iMode = 2'($urandom_range(0, 3));
            chkw("serial", oSerial, tx_m[tick % 4]);
            chk1("start_c", oStartCipher, k == 4 && j.mode[0]);
            chk1("start_d", oStartDecipher, k == 4 && j.mode[1]);
            iDoneCipher = (j.dc >= 0) && (k + 1 == 5 + j.dc);
            iDoneDecipher = (j.dd >= 0) && (k + 1 == 5 + j.dd);
            if (oResultValid) begin
                lat = k;
                break;
            end
            chk1("ready_busy", oReady, 1'b0);
        end
        iDoneCipher = 1'b0;
        iDoneDecipher = 1'b0;
        chki("latency", lat, j.lat);
        chk1("error", oError, j.err);
        if (!j.err) begin
            for (int i = 0; i < 4; i++) rx_m[i] = res[i];
        end
        check_outs("res");
        for (int h = 0; h < j.hold; h++) begin
            @(negedge clk);
            chk1("hold_valid", oResultValid, 1'b1);
            chk1("hold_err", oError, j.err);
            chkw("hold_serial", oSerial, tx_m[tick % 4]);
            check_outs("hold");
        end
        iValid = 1'b0;
        iResultReady = 1'b1;
        @(negedge clk);
        iResultReady = 1'b0;
        chk1("drop_valid", oResultValid, 1'b0);
        chk1("drop_err", oError, 1'b0);
        chk1("drop_ready", oReady, 1'b1);
    endtask

    job_t tbl [9];
    job_t rj;
    bit   rerr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b01, 40, -1, 10, 2, 50, 1'b0};
        tbl[1] = '{2'b00, -1, -1, 0, 0, 10, 1'b0};
        tbl[2] = '{2'b11, -1, -1, 0, 1, 105, 1'b1};
        tbl[3] = '{2'b11, 30, 10, 2, 3, 40, 1'b0};
        tbl[4] = '{2'b01, -1, 10, 0, 2, 105, 1'b1};
        tbl[5] = '{2'b10, -1, 0, 1, 0, 11, 1'b0};
        tbl[6] = '{2'b11, 3, 3, 0, 1, 13, 1'b0};
        tbl[7] = '{2'b01, 99, -1, 0, 3, 109, 1'b0};
        tbl[8] = '{2'b10, 50, -1, 0, 0, 105, 1'b1};
        for (int i = 0; i < 4; i++) begin
            res[i]  = '0;
            tx_m[i] = '0;
            rx_m[i] = '0;
        end

        // Reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_ready", oReady, 1'b1);
        chk1("rst_valid", oResultValid, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chkw("rst_serial", oSerial, '0);
            chk1("rst_sc", oStartCipher, 1'b0);
            chk1("rst_sd", oStartDecipher, 1'b0);
            chk1("rst_err", oError, 1'b0);
            chk1("rst_rv", oResultValid, 1'b0);
            chk1("rst_rdy", oReady, 1'b1);
            @(negedge clk);
        end
        check_outs("rst");

        // Job table
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                words[0] = 64'h1111111111111111;
                words[1] = 64'h2222222222222222;
                words[2] = 64'h3333333333333333;
                words[3] = 64'h4444444444444444;
                res[0] = 64'hAAAAAAAAAAAAAAAA;
                res[1] = 64'hBBBBBBBBBBBBBBBB;
                res[2] = 64'hCCCCCCCCCCCCCCCC;
                res[3] = 64'hDDDDDDDDDDDDDDDD;
            end else begin
                for (int w = 0; w < 4; w++) begin
                    words[w] = rnd64();
                    res[w] = rnd64();
                end
            end
            run_job(tbl[i]);
        end

        // Reset during WAIT
        for (int w = 0; w < 4; w++) begin
            words[w] = rnd64();
            res[w] = rnd64();
        end
        wait_align(0);
        iA = words[0];
        iB = words[1];
        iA_cipher = words[2];
        iB_cipher = words[3];
        iMode = 2'b11;
        iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        repeat (20) @(negedge clk);
        chk1("mid_busy", oReady, 1'b0);
        rst = 1'b0;
        #1;
        chk1("mid_sc", oStartCipher, 1'b0);
        chk1("mid_sd", oStartDecipher, 1'b0);
        chk1("mid_rv", oResultValid, 1'b0);
        chk1("mid_err", oError, 1'b0);
        chkw("mid_serial", oSerial, '0);
        for (int i = 0; i < 4; i++) begin
            tx_m[i] = '0;
            rx_m[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("post_rdy", oReady, 1'b1);
            chk1("post_sc", oStartCipher, 1'b0);
            chk1("post_sd", oStartDecipher, 1'b0);
            chkw("post_serial", oSerial, '0);
        end
        check_outs("post");
        rj = '{2'b11, 7, 12, 1, 1, 22, 1'b0};
        run_job(rj);

        // Random jobs against the latency/data model
        for (int n = 0; n < 10; n++) begin
            for (int w = 0; w < 4; w++) begin
                words[w] = rnd64();
                res[w] = rnd64();
            end
            rj.mode  = 2'($urandom_range(0, 3));
            rj.dc    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 60));
            rj.dd    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 60));
            rj.hold  = int'($urandom_range(0, 3));
            rj.align = int'($urandom_range(0, 3));
            rj.lat   = model_lat(rj.mode, rj.dc, rj.dd, rerr);
            rj.err   = rerr;
            run_job(rj);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc5_serial_host.md
Name: rc5_serial_host

Overview:
- Host-side counterpart of the RC5 serialized implementation wrapper.
- Accepts one parallel job of four W-bit words: cipher A/B and decipher A/B.
- Time-multiplexes the four words onto the wrapper's single serial input bus, and pulses the cipher/decipher start strobes.
- Waits for the done flags, de-serializes the four result words from the wrapper's serial output bus, and presents them with a valid/ready handshake.

Parameters:
W, 64, word width in bits (16/32/64 supported).
TIMEOUT, 1024, max cycles in WAIT before aborting with error; minimum 1.
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
iValid  in  1  job request valid
oReady  out  1  host can accept a job (IDLE only)
iMode  in  2  bit0 = run cipher, bit1 = run decipher
iA  in  W  plaintext A
iB  in  W  plaintext B
iA_cipher  in  W  ciphertext A
iB_cipher  in  W  ciphertext B
oSerial  out  W  to wrapper serial input
iSerial  in  W  from wrapper serial output
oStartCipher  out  1  one-cycle start strobe
oStartDecipher  out  1  one-cycle start strobe
iDoneCipher  in  1  cipher done
iDoneDecipher  in  1  decipher done
oResultValid  out  1  result words valid
iResultReady  in  1  consumer accepts result
oA_cipher  out  W  cipher output A
oB_cipher  out  W  cipher output B
oA_decipher  out  W  decipher output A
oB_decipher  out  W  decipher output B
oError  out  1  job aborted by timeout; valid with oResultValid

Behaviour:
- Reset (rst low, async) clears:
  - all tx/rx word registers, FSM state and counters; slot=0.
  - all outputs to 0, except oReady=1 (IDLE).
- slot: 2-bit free-running counter, 0 at reset, +1 every cycle, wraps 3->0. Matches the wrapper's internal mux counter when both leave reset on the same edge.
- oSerial = tx[slot], combinational from registers; tx order is 0:A, 1:B, 2:A_cipher, 3:B_cipher.
- Capture in CAPTURE state only: at each edge, rx[(slot-1) mod 4] <= iSerial. This reflects the wrapper's one-cycle registered output; rx order is 0:A_cipher, 1:B_cipher, 2:A_decipher, 3:B_decipher.
- FSM:
  - IDLE:
    - oReady=1.
    - On iValid: latch the four words and iMode; go LOAD with cnt=0.
  - LOAD:
    - Stay exactly 4 cycles so every slot edge presents the new word once.
    - Then go START.
  - START (1 cycle):
    - oStartCipher=mode[0] and oStartDecipher=mode[1], registered, high for exactly this cycle.
    - Clear done flags and the timeout counter.
    - Next state: WAIT; if mode==00, go straight to CAPTURE.
  - WAIT:
    - Sticky flags set on iDoneCipher / iDoneDecipher.
    - Leave for CAPTURE when every enabled operation's flag is set. Done flags for disabled operations are ignored.
    - Timeout counter +1 per cycle. At TIMEOUT, set oError=1 and go RESULT; rx holds its previous contents.
  - CAPTURE:
    - Stay 5 cycles: one cycle of wrapper output latency plus a full slot rotation.
    - Then go RESULT.
  - RESULT:
    - oResultValid=1; outputs driven from rx and stable.
    - On iResultReady, go IDLE; oResultValid and oError clear on the same edge.
- iValid outside IDLE is ignored (oReady=0); tx is not altered.
- A job accepted on the same edge as any slot value behaves identically; no alignment wait is required.
- Simultaneous done arrivals, or arrival in the same cycle as START exit, are handled by the sticky flags.
- Reset mid-job aborts with no further strobes; the next job starts from IDLE.
- Minimum job latency, accept to oResultValid (mode 00): 4 + 1 + 5 = 10 cycles.

Test Plan:
1. Reset:
   - Hold rst low 3 cycles, release.
   - Required: all outputs 0 except oReady=1; oSerial=0; slot counts 0,1,2,3,0.
2. Load sequence:
   - Accept job at slot 2: A=0x1111111111111111, B=0x2222222222222222, A_cipher=0x3333333333333333, B_cipher=0x4444444444444444, mode=01.
   - Required: oSerial tracks word[slot] every cycle.
   - Required: oStartCipher high exactly once, 5 cycles after accept; oStartDecipher stays 0.
3. Result capture:
   - Bench model of the wrapper (registered 4-slot output mux) returns 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. and asserts done 40 cycles after start.
   - Hold iResultReady low for 10 cycles.
   - Required: oResultValid rises 6 cycles after done and holds the four words unchanged; drops one cycle after ready; oError=0.
4. Timeout:
   - TIMEOUT=100, mode=11, never assert done.
   - Required: oResultValid=1 and oError=1 exactly 100 cycles after WAIT entry; no extra start strobes.
5. Mixed done timing:
   - mode=11, iDoneDecipher at +10, iDoneCipher at +30.
   - Required: CAPTURE entered only after +30.
   - Repeat with mode=01 and only iDoneDecipher asserted: required timeout.
6. Reset mid-operation:
   - Assert rst during WAIT.
   - Required: outputs immediately 0, oReady=1 after release, no strobe.
   - Required: a new job completes normally.
